// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM encoding,
// default byte width and a constant-foldable ceil(log2) helper.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    START     = 2'b01,
    WAIT_BUSY = 2'b10,
    WAIT_DONE = 2'b11
  } state_t;

  // Returns at least 1 so single-entry ranges still get a usable index width.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping past the top index back to zero.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [clog2(N_REQ)-1:0] ptr,
  output logic                    valid,
  output logic [clog2(N_REQ)-1:0] idx
);

  localparam int IW = clog2(N_REQ);
  localparam logic [IW:0] N_L = (IW+1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IW-1:0]      pos;
  logic [IW:0]        sum;

  always_comb begin
    // Rotate so the pointer position lands at bit 0, then lowest-bit-wins.
    dbl = {req, req};
    rot = dbl[ptr +: N_REQ];
    pos = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = IW'(i);
    end
    sum = {1'b0, pos} + {1'b0, ptr};
    if (sum >= N_L) sum = sum - N_L;
    idx   = sum[IW-1:0];
    valid = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources;
// grants one byte per frame and watches the transmitter's busy handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [clog2(N_REQ)-1:0]   grant_idx,
  output logic                      arb_busy,
  output logic                      timeout_err,
  output state_t                    state_dbg,
  output logic [clog2(N_REQ)-1:0]   rr_ptr_dbg
);

  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(BUSY_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST  = CW'(BUSY_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  // Handshake: a source holds req high with stable data until ack pulses for
  // one cycle; tx_start pulses once per grant and the transmitter answers by
  // raising tx_busy for the frame, then dropping it when the line is free.

  state_t              state, state_d;
  logic [IW-1:0]       rr_ptr, rr_ptr_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [N_REQ-1:0]    ack_d;
  logic                tx_start_d;
  logic [DATA_W-1:0]   tx_data_d;
  logic [IW-1:0]       grant_idx_d;
  logic                arb_busy_d;
  logic                timeout_err_d;

  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic [DATA_W-1:0]   pick_data;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) pick_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d       = state;
    rr_ptr_d      = rr_ptr;
    cnt_d         = cnt;
    ack_d         = '0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data;
    grant_idx_d   = grant_idx;
    timeout_err_d = timeout_err;
    case (state)
      IDLE: begin
        // A busy transmitter here belongs to someone else; hold off granting.
        if (pick_valid && !tx_busy) begin
          state_d     = START;
          tx_start_d  = 1'b1;
          ack_d       = N_REQ'(1) << pick_idx;
          tx_data_d   = pick_data;
          grant_idx_d = pick_idx;
        end
      end
      START: begin
        rr_ptr_d = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt == TO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered so arb_busy tracks the state it will describe next cycle.
    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_idx   <= '0;
      arb_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      cnt         <= cnt_d;
      ack         <= ack_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      grant_idx   <= grant_idx_d;
      arb_busy    <= arb_busy_d;
      timeout_err <= timeout_err_d;
    end
  end

  assign state_dbg  = state;
  assign rr_ptr_dbg = rr_ptr;

endmodule
